// File: rtl/cabac_byte_feeder.sv
// rtl/cabac_byte_feeder.sv - show-ahead byte FIFO feeding the CABAC decoder core.
// Optional EPB_REMOVE_EN strips 00 00 03 emulation-prevention bytes on the push side.
module cabac_byte_feeder #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 24
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   output logic                     in_ready,
   input  logic                     req,
   output logic [7:0]               data_out,
   output logic                     data_valid,
   output logic                     stall,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         bytes_consumed,
   output logic                     underflow_err
`ifdef EPB_REMOVE_EN
   ,
   output logic [15:0]              epb_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [7:0]       mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             uflow_q, uflow_d;
   logic             push, pop, store;

   // Level is kept separately from the pointers so full and empty are unambiguous.
   assign in_ready       = (level_q != LW'(DEPTH));
   assign data_valid     = (level_q != '0);
   assign data_out       = data_valid ? mem_q[rd_ptr_q] : 8'h00;
   assign stall          = req & ~data_valid;
   assign push           = in_valid & in_ready;
   assign pop            = req & data_valid;
   assign level          = level_q;
   assign bytes_consumed = cnt_q;
   assign underflow_err  = uflow_q;

`ifdef EPB_REMOVE_EN
   logic [1:0]  zero_run_q, zero_run_d;
   logic [15:0] epb_q, epb_d;
   logic        discard;

   // The third byte of 00 00 03 completes its handshake but is never written.
   assign discard   = push & (zero_run_q == 2'd2) & (in_data == 8'h03);
   assign store     = push & ~discard;
   assign epb_count = epb_q;

   always_comb begin
      zero_run_d = zero_run_q;
      epb_d      = epb_q;
      if (flush) begin
         zero_run_d = 2'd0;
         epb_d      = 16'h0000;
      end else if (push) begin
         if (discard) begin
            zero_run_d = 2'd0;
            if (epb_q != 16'hFFFF) epb_d = epb_q + 16'd1;
         end else if (in_data == 8'h00) begin
            zero_run_d = (zero_run_q == 2'd2) ? 2'd2 : zero_run_q + 2'd1;
         end else begin
            zero_run_d = 2'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         zero_run_q <= 2'd0;
         epb_q      <= 16'h0000;
      end else begin
         zero_run_q <= zero_run_d;
         epb_q      <= epb_d;
      end
   end
`else
   assign store = push;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      cnt_d    = cnt_q;
      uflow_d  = uflow_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         cnt_d    = '0;
         uflow_d  = 1'b0;
      end else begin
         if (store) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d    = cnt_q + CNT_W'(1);
         end
         if (stall) uflow_d = 1'b1;
         case ({store, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         cnt_q    <= '0;
         uflow_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         cnt_q    <= cnt_d;
         uflow_q  <= uflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (store && !flush) mem_q[wr_ptr_q] <= in_data;
   end

endmodule

// File: tb/tb_cabac_byte_feeder.sv
// tb/tb_cabac_byte_feeder.sv - self-checking bench for cabac_byte_feeder.
module tb_cabac_byte_feeder;

   localparam int DEPTH = 8;
   localparam int CNT_W = 24;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset, flush, in_valid, req;
   logic [7:0]       in_data;
   logic             in_ready, data_valid, stall, underflow_err;
   logic [7:0]       data_out;
   logic [LW-1:0]    level;
   logic [CNT_W-1:0] bytes_consumed;
`ifdef EPB_REMOVE_EN
   logic [15:0]      epb_count;
`endif

   cabac_byte_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .req(req), .data_out(data_out), .data_valid(data_valid), .stall(stall),
      .level(level), .bytes_consumed(bytes_consumed), .underflow_err(underflow_err)
`ifdef EPB_REMOVE_EN
      , .epb_count(epb_count)
`endif
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a plain byte queue plus counters.
   logic [7:0]  mq[$];
   int unsigned m_bytes;
   bit          m_uf;
   int          m_zr;
   int unsigned m_epb;

   task automatic model_cycle(input bit iv, input logic [7:0] d, input bit rq, input bit fl);
      bit rdy;
      in_valid = iv; in_data = d; req = rq; flush = fl;
      #1;
      check("m in_ready",   in_ready,   mq.size() != DEPTH);
      check("m data_valid", data_valid, mq.size() != 0);
      check("m data_out",   data_out,   (mq.size() != 0) ? mq[0] : 8'h00);
      check("m stall",      stall,      rq && mq.size() == 0);
      check("m level",      level,      mq.size());
      check("m bytes",      bytes_consumed, m_bytes);
      check("m underflow",  underflow_err,  m_uf);
`ifdef EPB_REMOVE_EN
      check("m epb_count",  epb_count,  m_epb);
`endif
      if (fl) begin
         mq.delete(); m_bytes = 0; m_uf = 0; m_zr = 0; m_epb = 0;
      end else begin
         rdy = (mq.size() != DEPTH);
         if (rq && mq.size() == 0) m_uf = 1;
         if (rq && mq.size() != 0) begin
            void'(mq.pop_front());
            m_bytes = (m_bytes + 1) % (1 << CNT_W);
         end
         if (iv && rdy) begin
`ifdef EPB_REMOVE_EN
            if (m_zr == 2 && d == 8'h03) begin
               m_zr = 0;
               if (m_epb != 16'hFFFF) m_epb++;
            end else begin
               mq.push_back(d);
               m_zr = (d == 8'h00) ? ((m_zr == 2) ? 2 : m_zr + 1) : 0;
            end
`else
            mq.push_back(d);
`endif
         end
      end
      tick();
      in_valid = 0; req = 0; flush = 0;
   endtask

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic       rq;
      logic       ir;
      logic       dv;
      logic [7:0] dout;
      logic       st;
      int         lvl;
   } vec_t;

   vec_t       tbl[9];
   logic [7:0] exp_seq[$];
   logic [7:0] rd;

   initial begin
      tbl[0] = '{1'b1, 8'h8C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
      tbl[1] = '{1'b1, 8'hD1, 1'b0, 1'b1, 1'b1, 8'h8C, 1'b0, 1};
      tbl[2] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'h8C, 1'b0, 2};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h8C, 1'b0, 3};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hD1, 1'b0, 2};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1};
      tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 0};
      tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};

      reset = 1; flush = 0; in_valid = 0; in_data = 0; req = 0;
      m_bytes = 0; m_uf = 0; m_zr = 0; m_epb = 0;
      repeat (2) tick();
      reset = 0;
      #1;
      check("rst in_ready",   in_ready,   1);
      check("rst data_valid", data_valid, 0);
      check("rst data_out",   data_out,   8'h00);
      check("rst level",      level,      0);
      check("rst stall",      stall,      0);
      check("rst bytes",      bytes_consumed, 0);
      check("rst underflow",  underflow_err,  0);
      tick();

      for (int i = 0; i < 9; i++) begin
         in_valid = tbl[i].iv; in_data = tbl[i].d; req = tbl[i].rq;
         #1;
         check($sformatf("vec%0d in_ready", i),   in_ready,   tbl[i].ir);
         check($sformatf("vec%0d data_valid", i), data_valid, tbl[i].dv);
         check($sformatf("vec%0d data_out", i),   data_out,   tbl[i].dout);
         check($sformatf("vec%0d stall", i),      stall,      tbl[i].st);
         check($sformatf("vec%0d level", i),      level,      tbl[i].lvl);
         tick();
      end
      check("seq bytes_consumed", bytes_consumed, 3);
      check("sticky underflow a", underflow_err, 1);
      tick();
      check("sticky underflow b", underflow_err, 1);

      // Flush with a push and a pop in the same cycle: both are discarded.
      in_valid = 1; in_data = 8'h77; tick(); in_valid = 0;
      flush = 1; in_valid = 1; in_data = 8'h55; req = 1;
      tick();
      flush = 0; in_valid = 0; req = 0;
      #1;
      check("flush level",     level,          0);
      check("flush bytes",     bytes_consumed, 0);
      check("flush underflow", underflow_err,  0);
      check("flush valid",     data_valid,     0);
      tick();

      // Fill to full, hold in_valid, then pop once.
      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1; in_data = 8'h10 + 8'(i);
         exp_seq.push_back(8'h10 + 8'(i));
         tick();
      end
      in_data = 8'hEE;
      #1;
      check("full in_ready", in_ready, 0);
      check("full level",    level,    DEPTH);
      tick();
      check("full hold level", level, DEPTH);
      req = 1;
      #1;
      check("full pop no bypass", in_ready, 0);
      check("full pop head", data_out, exp_seq.pop_front());
      tick();
      req = 0;
      #1;
      check("after pop in_ready", in_ready, 1);
      check("after pop level",    level,    DEPTH - 1);
      exp_seq.push_back(8'hEE);
      tick();
      in_valid = 0;
      #1;
      check("refill level", level, DEPTH);
      for (int k = 0; k < DEPTH; k++) begin
         req = 1;
         #1;
         rd = exp_seq.pop_front();
         check($sformatf("drain%0d data_out", k), data_out, rd);
         tick();
      end
      req = 0;
      #1;
      check("drain level", level, 0);
      check("drain valid", data_valid, 0);
      tick();

      // Asynchronous reset mid-cycle drops stored bytes immediately.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_data = 8'hC0 + 8'(i); tick();
      end
      in_valid = 0;
      #1;
      check("pre-reset level", level, 3);
      #2 reset = 1;
      #1;
      check("async reset level", level, 0);
      check("async reset valid", data_valid, 0);
      check("async reset bytes", bytes_consumed, 0);
      tick();
      reset = 0;
      mq.delete(); m_bytes = 0; m_uf = 0; m_zr = 0; m_epb = 0;
      tick();

      // Randomized traffic against the queue model.
      model_cycle(0, 8'h00, 0, 1);
      for (int c = 0; c < 400; c++) begin
         logic [7:0] d;
         case ($urandom_range(0, 3))
            0:       d = 8'h00;
            1:       d = 8'h03;
            default: d = 8'($urandom);
         endcase
         if (c < 200)
            model_cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0);
         else
            model_cycle($urandom_range(0, 2) == 0, d, $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
      end

      // Steady push+pop at level 4 across pointer wrap.
      model_cycle(0, 8'h00, 0, 1);
      for (int i = 0; i < 4; i++) model_cycle(1, 8'h40 + 8'(i), 0, 0);
      for (int i = 0; i < 20; i++) model_cycle(1, 8'($urandom), 1, 0);
      #1;
      check("steady level", level, 4);
      check("steady bytes", bytes_consumed, 20);

      // Emulation-prevention sequence.
      model_cycle(0, 8'h00, 0, 1);
      model_cycle(1, 8'h00, 0, 0);
      model_cycle(1, 8'h00, 0, 0);
      model_cycle(1, 8'h03, 0, 0);
      model_cycle(1, 8'h01, 0, 0);
      #1;
`ifdef EPB_REMOVE_EN
      check("epb level", level, 3);
      check("epb count", epb_count, 1);
      exp_seq = '{8'h00, 8'h00, 8'h01};
`else
      check("epb level", level, 4);
      exp_seq = '{8'h00, 8'h00, 8'h03, 8'h01};
`endif
      while (exp_seq.size() != 0) begin
         rd = exp_seq.pop_front();
         check("epb order", data_out, rd);
         model_cycle(0, 8'h00, 1, 0);
         #1;
      end
      model_cycle(1, 8'h00, 0, 0);
      model_cycle(1, 8'h03, 0, 0);
      #1;
      check("epb pair level", level, 2);
`ifdef EPB_REMOVE_EN
      check("epb pair count", epb_count, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
